// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants, types and decode helpers for the MEM-stage access controller.
package mem_access_ctrl_pkg;

    // MIPS load/store opcodes
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    // Exception cause codes
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;
    localparam logic [4:0] EXC_RI   = 5'd10;

    localparam logic [31:0] PC_INIT   = 32'hBFC0_0000;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mac_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    // Access width implied by the opcode; anything unrecognised is treated as a word.
    function automatic acc_size_e op_size(input logic [5:0] op);
        acc_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Zero-extending loads
    function automatic logic op_unsigned(input logic [5:0] op);
        return (op == OP_LBU) || (op == OP_LHU);
    endfunction

    // Natural-alignment check for the given access width
    function automatic logic is_misaligned(input acc_size_e sz, input logic [1:0] lo);
        logic mis;
        case (sz)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = (lo != 2'b00);
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: byte enables and store replication on the way out,
// lane extraction and sign/zero extension of read data on the way back.
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    acc_size_e   size_s;
    logic        uns_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign size_s = op_size(op);
    assign uns_s  = op_unsigned(op);

    // Lane selection and extension for the access width
    always_comb begin
        be        = 4'b0000;
        wdata     = rt;
        load_data = ZERO_WORD;
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        case (size_s)
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{rt[7:0]}};
                case (addr_lo)
                    2'd0:    byte_s = rdata[7:0];
                    2'd1:    byte_s = rdata[15:8];
                    2'd2:    byte_s = rdata[23:16];
                    2'd3:    byte_s = rdata[31:24];
                    default: byte_s = rdata[7:0];
                endcase
                if (uns_s) begin
                    load_data = {24'h00_0000, byte_s};
                end else begin
                    load_data = {{24{byte_s[7]}}, byte_s};
                end
            end
            SZ_HALF: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{rt[15:0]}};
                if (addr_lo[1]) begin
                    half_s = rdata[31:16];
                end else begin
                    half_s = rdata[15:0];
                end
                if (uns_s) begin
                    load_data = {16'h0000, half_s};
                end else begin
                    load_data = {{16{half_s[15]}}, half_s};
                end
            end
            SZ_WORD: begin
                be        = 4'b1111;
                wdata     = rt;
                load_data = rdata;
            end
            default: begin
                be        = 4'b1111;
                wdata     = rt;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller and MEM/WB pipeline register.
// Runs a req/ack bus handshake for aligned loads/stores, stalls upstream
// until it completes, and reports RI/AdEL/AdES/DBE alongside writeback.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_mux_3,
    input  logic        mem_drce,
    input  logic        mem_dwce,
    input  logic        mem_wce,
    input  logic [5:0]  mem_op,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_rt,
    input  logic [4:0]  mem_rwa,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic        wb_wce,
    output logic [4:0]  wb_rwa,
    output logic [31:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        exc_valid,
    output logic [4:0]  exc_code
);

    localparam int CNT_W   = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam int TO_LAST = (BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    mac_state_e       state_r;
    logic [CNT_W-1:0] to_cnt_r;
    logic             bus_err_r;
    logic [31:0]      rdata_r;

    logic             access_s;
    logic             both_s;
    logic             misalign_s;
    logic             aligned_acc_s;
    logic [3:0]       be_s;
    logic [31:0]      wdata_s;
    logic [31:0]      load_data_s;
    logic [4:0]       exc_code_s;

    assign access_s      = mem_drce ^ mem_dwce;
    assign both_s        = mem_drce & mem_dwce;
    assign misalign_s    = access_s & is_misaligned(op_size(mem_op), mem_alu_out[1:0]);
    assign aligned_acc_s = access_s & ~misalign_s;

    // Load extraction works on the captured read word; the EXE/MEM inputs are
    // frozen by the stall, so the address bits are still valid in DONE.
    mem_lane_align u_lane (
        .op        (mem_op),
        .addr_lo   (mem_alu_out[1:0]),
        .rt        (mem_rt),
        .rdata     (rdata_r),
        .be        (be_s),
        .wdata     (wdata_s),
        .load_data (load_data_s)
    );

    // Upstream freeze: the launching IDLE cycle plus every REQ cycle
    always_comb begin
        mem_stall = 1'b0;
        if (state_r == ST_REQ) begin
            mem_stall = 1'b1;
        end else if (state_r == ST_IDLE) begin
            mem_stall = aligned_acc_s;
        end else begin
            mem_stall = 1'b0;
        end
    end

    // Exception cause for the instruction leaving the stage this cycle
    always_comb begin
        exc_code_s = EXC_NONE;
        if (both_s) begin
            exc_code_s = EXC_RI;
        end else if (misalign_s) begin
            exc_code_s = mem_drce ? EXC_ADEL : EXC_ADES;
        end else if ((state_r == ST_DONE) && bus_err_r) begin
            exc_code_s = EXC_DBE;
        end else begin
            exc_code_s = EXC_NONE;
        end
    end

    // Bus handshake FSM; ack is only honoured in REQ so stray acks are harmless
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            to_cnt_r  <= CNT_ZERO;
            bus_err_r <= 1'b0;
            rdata_r   <= ZERO_WORD;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= ZERO_WORD;
            dm_be     <= 4'b0000;
            dm_wdata  <= ZERO_WORD;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    to_cnt_r <= CNT_ZERO;
                    if (aligned_acc_s) begin
                        dm_req    <= 1'b1;
                        dm_we     <= mem_dwce;
                        dm_addr   <= {mem_alu_out[31:2], 2'b00};
                        dm_be     <= be_s;
                        dm_wdata  <= wdata_s;
                        bus_err_r <= 1'b0;
                        state_r   <= ST_REQ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (dm_ack) begin
                        rdata_r <= dm_rdata;
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        state_r <= ST_DONE;
                    end else if ((BUS_TIMEOUT != 0) && (to_cnt_r == CNT_LAST)) begin
                        bus_err_r <= 1'b1;
                        dm_req    <= 1'b0;
                        dm_we     <= 1'b0;
                        state_r   <= ST_DONE;
                    end else begin
                        to_cnt_r  <= to_cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    to_cnt_r <= CNT_ZERO;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    dm_req  <= 1'b0;
                    dm_we   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: bubble while stalled, otherwise advance with the result
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wce    <= 1'b0;
            wb_rwa    <= 5'd0;
            wb_data   <= ZERO_WORD;
            wb_pc     <= PC_INIT;
            exc_valid <= 1'b0;
            exc_code  <= EXC_NONE;
        end else if (mem_stall) begin
            wb_wce    <= 1'b0;
            exc_valid <= 1'b0;
            exc_code  <= EXC_NONE;
        end else begin
            wb_data   <= mem_mux_3 ? load_data_s : mem_alu_out;
            wb_wce    <= mem_wce & (exc_code_s == EXC_NONE);
            wb_rwa    <= mem_rwa;
            wb_pc     <= mem_pc;
            exc_valid <= (exc_code_s != EXC_NONE);
            exc_code  <= exc_code_s;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset
// corner cases, and randomized instructions against a behavioural model.
module tb_mem_access_ctrl;

    localparam int TO = 4;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_mux_3, mem_drce, mem_dwce, mem_wce;
    logic [5:0]  mem_op;
    logic [31:0] mem_pc, mem_alu_out, mem_rt;
    logic [4:0]  mem_rwa;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata, dm_rdata;
    logic        dm_ack;
    logic        mem_stall, wb_wce, exc_valid;
    logic [4:0]  wb_rwa, exc_code;
    logic [31:0] wb_data, wb_pc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_mux_3(mem_mux_3), .mem_drce(mem_drce), .mem_dwce(mem_dwce), .mem_wce(mem_wce),
        .mem_op(mem_op), .mem_pc(mem_pc), .mem_alu_out(mem_alu_out), .mem_rt(mem_rt),
        .mem_rwa(mem_rwa),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .mem_stall(mem_stall),
        .wb_wce(wb_wce), .wb_rwa(wb_rwa), .wb_data(wb_data), .wb_pc(wb_pc),
        .exc_valid(exc_valid), .exc_code(exc_code)
    );

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic        drce, dwce, wce, mux3;
        logic [4:0]  rwa;
        logic [31:0] pc;
        int          ack_delay;   // REQ cycle index carrying ack; -1 or >= TO means never
        logic [31:0] rdata;
        logic        exp_bus, exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata, exp_wb_data;
        logic [4:0]  exp_code;
        logic        exp_wce;
        logic        chk_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                input logic drce, input logic dwce, input logic wce, input logic mux3,
                                input logic [4:0] rwa, input int ack_delay, input logic [31:0] rdata,
                                input logic exp_bus, input logic exp_we, input logic [3:0] exp_be,
                                input logic [31:0] exp_wdata, input logic [31:0] exp_wb_data,
                                input logic [4:0] exp_code, input logic exp_wce, input logic chk_data);
        vec_t v;
        v.op = op; v.addr = addr; v.rt = rt; v.drce = drce; v.dwce = dwce; v.wce = wce;
        v.mux3 = mux3; v.rwa = rwa; v.pc = 32'h0; v.ack_delay = ack_delay; v.rdata = rdata;
        v.exp_bus = exp_bus; v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wdata = exp_wdata;
        v.exp_wb_data = exp_wb_data; v.exp_code = exp_code; v.exp_wce = exp_wce; v.chk_data = chk_data;
        return v;
    endfunction

    // Reference model: derives every expectation from the access rules with plain arithmetic
    function automatic vec_t model(input vec_t v);
        int          size;
        int          lane;
        bit          uns, is_ld, is_st, mis;
        logic [31:0] mask, raw;
        case (v.op)
            6'h20, 6'h24, 6'h28: size = 1;
            6'h21, 6'h25, 6'h29: size = 2;
            default:             size = 4;
        endcase
        uns   = (v.op == 6'h24) || (v.op == 6'h25);
        is_ld = v.drce && !v.dwce;
        is_st = v.dwce && !v.drce;
        lane  = int'(v.addr % 32'd4);
        mis   = (is_ld || is_st) && ((lane % size) != 0);
        v.exp_bus = (is_ld || is_st) && !mis;
        v.exp_we  = is_st;
        v.exp_be  = 4'((((32'd1 << size) - 32'd1) << lane));
        if (size == 1)      v.exp_wdata = (v.rt & 32'hFF) * 32'h0101_0101;
        else if (size == 2) v.exp_wdata = (v.rt & 32'hFFFF) * 32'h0001_0001;
        else                v.exp_wdata = v.rt;
        if (v.drce && v.dwce)                                            v.exp_code = 5'd10;
        else if (mis)                                                    v.exp_code = is_ld ? 5'd4 : 5'd5;
        else if (v.exp_bus && (v.ack_delay < 0 || v.ack_delay >= TO))    v.exp_code = 5'd7;
        else                                                             v.exp_code = 5'd0;
        v.exp_wce = v.wce && (v.exp_code == 5'd0);
        mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        raw  = (v.rdata >> (8 * lane)) & mask;
        if (!uns && size != 4 && ((raw >> (8 * size - 1)) & 32'd1) == 32'd1) raw = raw | ~mask;
        v.exp_wb_data = v.mux3 ? raw : v.addr;
        v.chk_data    = (v.exp_code == 5'd0) && (!v.mux3 || (is_ld && v.exp_bus));
        return v;
    endfunction

    // Present one instruction at posedge+1, play the bus slave, check the stage to writeback
    task automatic run_instr(input vec_t v);
        int n_req;
        mem_op = v.op; mem_alu_out = v.addr; mem_rt = v.rt; mem_drce = v.drce; mem_dwce = v.dwce;
        mem_wce = v.wce; mem_mux_3 = v.mux3; mem_rwa = v.rwa; mem_pc = v.pc;
        dm_ack = 1'b0; dm_rdata = $urandom;
        if (v.exp_bus) begin
            n_req = (v.ack_delay >= 0 && v.ack_delay < TO) ? v.ack_delay + 1 : TO;
            @(negedge clk);
            chk("stall_launch", {31'd0, mem_stall}, 32'd1);
            chk("req_launch",   {31'd0, dm_req},    32'd0);
            for (int k = 0; k < n_req; k++) begin
                @(posedge clk); #1;
                dm_ack   = (k == v.ack_delay);
                dm_rdata = (k == v.ack_delay) ? v.rdata : $urandom;
                @(negedge clk);
                chk("stall_req",  {31'd0, mem_stall}, 32'd1);
                chk("dm_req_req", {31'd0, dm_req},    32'd1);
                chk("bubble_wce", {31'd0, wb_wce},    32'd0);
                chk("bubble_exc", {31'd0, exc_valid}, 32'd0);
                if (k == 0) begin
                    chk("dm_addr",  dm_addr, v.addr & 32'hFFFF_FFFC);
                    chk("dm_be",    {28'd0, dm_be}, {28'd0, v.exp_be});
                    chk("dm_we",    {31'd0, dm_we}, {31'd0, v.exp_we});
                    chk("dm_wdata", dm_wdata, v.exp_wdata);
                end
            end
            @(posedge clk); #1;
            dm_ack = 1'($urandom_range(0, 1));
            dm_rdata = $urandom;
            @(negedge clk);
            chk("stall_done",  {31'd0, mem_stall}, 32'd0);
            chk("dm_req_done", {31'd0, dm_req},    32'd0);
        end else begin
            dm_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("stall_nobus", {31'd0, mem_stall}, 32'd0);
            chk("req_nobus",   {31'd0, dm_req},    32'd0);
        end
        @(posedge clk); #1;
        chk("wb_wce",    {31'd0, wb_wce},    {31'd0, v.exp_wce});
        chk("exc_valid", {31'd0, exc_valid}, {31'd0, (v.exp_code != 5'd0)});
        chk("exc_code",  {27'd0, exc_code},  {27'd0, v.exp_code});
        chk("wb_rwa",    {27'd0, wb_rwa},    {27'd0, v.rwa});
        chk("wb_pc",     wb_pc, v.pc);
        if (v.chk_data) chk("wb_data", wb_data, v.exp_wb_data);
    endtask

    task automatic drive_idle();
        mem_op = 6'h00; mem_alu_out = 32'h0; mem_rt = 32'h0; mem_drce = 1'b0; mem_dwce = 1'b0;
        mem_wce = 1'b0; mem_mux_3 = 1'b0; mem_rwa = 5'd0; mem_pc = 32'h0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_dm_req"},    {31'd0, dm_req},    32'd0);
        chk({tag, "_dm_we"},     {31'd0, dm_we},     32'd0);
        chk({tag, "_dm_addr"},   dm_addr,            32'd0);
        chk({tag, "_dm_be"},     {28'd0, dm_be},     32'd0);
        chk({tag, "_dm_wdata"},  dm_wdata,           32'd0);
        chk({tag, "_wb_wce"},    {31'd0, wb_wce},    32'd0);
        chk({tag, "_wb_rwa"},    {27'd0, wb_rwa},    32'd0);
        chk({tag, "_wb_data"},   wb_data,            32'd0);
        chk({tag, "_wb_pc"},     wb_pc,              RESET_PC);
        chk({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd0);
        chk({tag, "_exc_code"},  {27'd0, exc_code},  32'd0);
        chk({tag, "_stall"},     {31'd0, mem_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic [5:0]  ops[8];
        logic [31:0] a;
        int          r;

        ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
        //                op     addr          rt            rd dw wce mux rwa ack rdata          bus we be       wdata          wb_data        code  wce chk
        tbl.push_back(mk(6'h23, 32'h0000_0100, 32'h1234_5678, 1, 0, 1, 1, 5'd8, 1, 32'hDEAD_BEEF, 1, 0, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF, 5'd0,  1, 1));
        tbl.push_back(mk(6'h20, 32'h0000_0103, 32'h0000_0000, 1, 0, 1, 1, 5'd9, 0, 32'h8011_2233, 1, 0, 4'b1000, 32'h0000_0000, 32'hFFFF_FF80, 5'd0,  1, 1));
        tbl.push_back(mk(6'h24, 32'h0000_0103, 32'h0000_0000, 1, 0, 1, 1, 5'd9, 2, 32'h8011_2233, 1, 0, 4'b1000, 32'h0000_0000, 32'h0000_0080, 5'd0,  1, 1));
        tbl.push_back(mk(6'h21, 32'h0000_0102, 32'h0000_0000, 1, 0, 1, 1, 5'd10, 0, 32'h8011_2233, 1, 0, 4'b1100, 32'h0000_0000, 32'hFFFF_8011, 5'd0, 1, 1));
        tbl.push_back(mk(6'h25, 32'h0000_0102, 32'h0000_0000, 1, 0, 1, 1, 5'd11, 3, 32'h8011_2233, 1, 0, 4'b1100, 32'h0000_0000, 32'h0000_8011, 5'd0, 1, 1));
        tbl.push_back(mk(6'h28, 32'h0000_0101, 32'h0000_00A5, 0, 1, 0, 0, 5'd0, 0, 32'h0000_0000, 1, 1, 4'b0010, 32'hA5A5_A5A5, 32'h0000_0101, 5'd0,  0, 1));
        tbl.push_back(mk(6'h29, 32'h0000_0102, 32'h0000_BEEF, 0, 1, 0, 0, 5'd0, 1, 32'h0000_0000, 1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0102, 5'd0,  0, 1));
        tbl.push_back(mk(6'h2B, 32'h0000_0104, 32'hCAFE_BABE, 0, 1, 0, 0, 5'd0, 0, 32'h0000_0000, 1, 1, 4'b1111, 32'hCAFE_BABE, 32'h0000_0104, 5'd0,  0, 1));
        tbl.push_back(mk(6'h23, 32'h0000_0102, 32'h0000_0000, 1, 0, 1, 1, 5'd4, 0, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 5'd4,  0, 0));
        tbl.push_back(mk(6'h29, 32'h0000_0101, 32'h0000_0000, 0, 1, 0, 0, 5'd0, 0, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 5'd5,  0, 0));
        tbl.push_back(mk(6'h23, 32'h0000_0200, 32'h0000_0000, 1, 0, 1, 1, 5'd5, -1, 32'h0000_0000, 1, 0, 4'b1111, 32'h0000_0000, 32'h0000_0000, 5'd7, 0, 0));
        tbl.push_back(mk(6'h00, 32'h1234_5678, 32'h0000_0000, 0, 0, 1, 0, 5'd3, 0, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h1234_5678, 5'd0,  1, 1));
        tbl.push_back(mk(6'h23, 32'h0000_0300, 32'h0000_0000, 1, 1, 1, 1, 5'd6, 0, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 5'd10, 0, 0));
        tbl.push_back(mk(6'h00, 32'h0BAD_F00D, 32'h0000_0000, 0, 0, 1, 0, 5'd7, 0, 32'h0000_0000, 0, 0, 4'b0000, 32'h0000_0000, 32'h0BAD_F00D, 5'd0,  1, 1));

        // Reset state
        rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_state("rst0");

        // Directed vector table
        foreach (tbl[i]) begin
            v = tbl[i];
            v.pc = 32'h0040_0000 + 32'(i) * 32'd4;
            run_instr(v);
        end

        // Reset while in REQ abandons the access; later acks are ignored
        mem_op = 6'h23; mem_alu_out = 32'h0000_0300; mem_rt = 32'h0; mem_drce = 1'b1; mem_dwce = 1'b0;
        mem_wce = 1'b1; mem_mux_3 = 1'b1; mem_rwa = 5'd12; mem_pc = 32'h0040_1000; dm_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_active", {31'd0, dm_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_idle();
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_mid");
        for (int k = 0; k < 3; k++) begin
            dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            chk("late_ack_req",   {31'd0, dm_req},    32'd0);
            chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
            chk("late_ack_exc",   {31'd0, exc_valid}, 32'd0);
        end
        dm_ack = 1'b0;

        // Randomized instructions against the reference model
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 9));
            v.op = ops[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (v.op == 6'h23 || v.op == 6'h2B) a = a & 32'hFFFF_FFFC;
                else if (v.op == 6'h21 || v.op == 6'h25 || v.op == 6'h29) a = a & 32'hFFFF_FFFE;
            end
            v.addr = a;
            v.rt = $urandom;
            v.rdata = $urandom;
            v.rwa = 5'($urandom_range(0, 31));
            v.pc = 32'h0050_0000 + 32'(n) * 32'd4;
            v.ack_delay = int'($urandom_range(0, TO + 1)) - 1;
            if (r < 7) begin
                v.dwce = (v.op[3] == 1'b1);
                v.drce = !v.dwce;
                v.mux3 = v.drce;
                v.wce  = v.drce ? 1'($urandom_range(0, 1)) : 1'b0;
            end else if (r < 9) begin
                v.op = 6'h00; v.drce = 1'b0; v.dwce = 1'b0; v.mux3 = 1'b0;
                v.wce = 1'($urandom_range(0, 1));
            end else begin
                v.drce = 1'b1; v.dwce = 1'b1; v.mux3 = 1'b1; v.wce = 1'b1;
            end
            run_instr(model(v));
        end

        drive_idle();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory access controller; consumes the EXE/MEM register outputs (mem_*) and drives a req/ack data-memory bus.
- Generates byte enables, store-data replication and load extraction/extension; stalls upstream until the access completes.
- Doubles as the MEM/WB register: registered wb_* outputs feed writeback.

Parameters:
- BUS_TIMEOUT, 255, REQ cycles without dm_ack before bus-error abort; 0 disables timeout.

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- mem_mux_3  in  1  1 = writeback data from memory, 0 = from ALU
- mem_drce  in  1  load access request
- mem_dwce  in  1  store access request
- mem_wce  in  1  register write enable
- mem_op  in  6  MIPS opcode (LB/LH/LW/LBU/LHU/SB/SH/SW)
- mem_pc  in  32  instruction PC
- mem_alu_out  in  32  effective address / ALU result
- mem_rt  in  32  store data
- mem_rwa  in  5  destination register
- dm_req  out  1  bus request, held until ack
- dm_we  out  1  1 = write
- dm_addr  out  32  word address, {mem_alu_out[31:2],2'b00}
- dm_be  out  4  byte enables, little-endian
- dm_wdata  out  32  replicated store data
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  access complete
- mem_stall  out  1  freeze PC/IF/ID/EXE and EXE/MEM register
- wb_wce, wb_rwa, wb_data, wb_pc  out  1/5/32/32  MEM/WB outputs
- exc_valid  out  1  one-cycle exception pulse, aligned with wb_*
- exc_code  out  5  4 AdEL, 5 AdES, 7 DBE, 10 RI

Behaviour:
- Reset (rst=1 at posedge): state IDLE, timeout counter 0, dm_req/dm_we 0, dm_addr/dm_wdata 0, dm_be 0, wb_wce 0, wb_rwa 0, wb_data 0, wb_pc PC_INIT, exc_valid 0, exc_code 0.
- Reset mid-transaction abandons the access; dm_req low the next cycle.
- access = mem_drce ^ mem_dwce.
- Both mem_drce and mem_dwce high: no bus access, exc RI, wb_wce 0.
- Misalignment:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0: no bus access, no stall, exc code 4 (load) or 5 (store), wb_wce 0.
- FSM states IDLE, REQ, DONE:
  - IDLE: aligned access -> latch addr/be/wdata/we, dm_req=1, go to REQ.
  - REQ: on dm_ack, capture dm_rdata, drop dm_req, go to DONE.
  - REQ timeout: counter reaches BUS_TIMEOUT (nonzero) -> drop dm_req, set bus-error flag, go to DONE.
  - DONE: unconditional return to IDLE; pipeline advances at the end of this cycle.
- mem_stall = (IDLE & aligned access) | REQ; combinational; low in DONE.
- dm_ack is ignored outside REQ; a late ack after abort or reset has no effect.
- Minimum latency: access seen in cycle N (stall), REQ in N+1 (ack allowed), DONE in N+2, wb_* valid in N+3.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << {addr[1],1'b0}.
  - Word: 1111.
- Store data: SB {4{rt[7:0]}}, SH {2{rt[15:0]}}, SW rt.
- Load data: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- MEM/WB register update each posedge:
  - mem_stall=1: wb_wce <= 0 (bubble), other wb_* hold.
  - mem_stall=0: wb_data <= mem_mux_3 ? load result : mem_alu_out; wb_wce <= mem_wce & no exception; wb_rwa/wb_pc <= inputs.
  - exc_valid/exc_code registered together with wb_*.
  - Bus error -> DBE, wb_wce 0.

Decomposition:
- Opcode constants (OP_LB..OP_SW), exception codes, FSM state encodings, PC_INIT and ZERO_WORD go in shared define.vh.
- One natural sub-module: mem_lane_align, combinational; handles be/wdata generation and load extraction/extension.

Test Plan:
- LW addr 0x100, ack on 2nd REQ cycle, rdata 0xDEADBEEF, wce=1, rwa=8 -> stall 3 cycles, dm_be 1111, wb_data 0xDEADBEEF, wb_rwa 8, wb_wce 1.
- LB/LBU addr 0x103, rdata 0x80112233 -> wb_data 0xFFFFFF80 / 0x00000080. LH addr 0x102 -> 0xFFFF8011.
- SB addr 0x101, rt 0x000000A5 -> dm_we 1, dm_be 0010, dm_wdata 0xA5A5A5A5. SH addr 0x102 -> dm_be 1100.
- LW addr 0x102 -> no dm_req, no stall, exc_valid 1 code 4, wb_wce 0. SH addr 0x101 -> code 5.
- BUS_TIMEOUT=4, no ack -> dm_req high 4 cycles, then DONE, exc code 7, wb_wce 0; ack arriving afterward is ignored.
- rst pulse while in REQ -> dm_req 0 and all outputs at reset values next cycle; back-to-back ALU op with mux_3=0 passes alu_out with 1-cycle latency.
